formula_pipe_arbiter: RTL and testbench

- Shares one instance of the team's 3-stage formula datapath, q = ((a-b)*(3c+1) - 4d) >>> 1, among NUM_REQ requesters.
- Selects requesters round-robin and issues one operand set per cycle.
- Tags each issue with the requester ID, matches tags to returning q_valid, and buffers results in a response FIFO with valid/ready backpressure.
- Uses credit-based flow control so the non-stallable datapath never overflows the FIFO.

---
 rtl/formula_pipe_arbiter_pkg.sv | 23 ++
 rtl/formula_pipe_arbiter_rsp_fifo.sv | 68 ++++++
 rtl/formula_pipe_arbiter.sv | 167 ++++++++++++++++
 tb/tb_formula_pipe_arbiter.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/formula_pipe_arbiter_pkg.sv
// Shared types and widths for the formula datapath and its round-robin front end.
// The datapath, the arbiter and the response FIFO all use these widths, so the
// arbiter's default parameters are taken from here.
package formula_pkg;

  localparam int DP_DATA_WIDTH = 5;
  localparam int DP_NUM_REQ    = 4;
  localparam int DP_ID_W       = $clog2(DP_NUM_REQ);
  localparam int DP_LATENCY    = 3;

  // One buffered result together with the requester it belongs to.
  typedef struct packed {
    logic signed [DP_DATA_WIDTH-1:0] q;
    logic        [DP_ID_W-1:0]       id;
  } rsp_entry_t;

  // Tag travelling alongside an operand set through the datapath.
  typedef struct packed {
    logic               vld;
    logic [DP_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/formula_pipe_arbiter_rsp_fifo.sv
// rsp_fifo: synchronous FIFO with push/pop, full/empty flags and an occupancy count.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, din         write request and data (ignored while full)
//   pop               read request (ignored while empty)
//   dout              head entry, forced to zero while empty
//   full, empty       occupancy flags
//   count             number of stored entries
module rsp_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: the storage array is deliberately not reset; only pointers and count
  // need a known value, and dout is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/formula_pipe_arbiter.sv
// formula_pipe_arbiter: shares one non-stallable 3-stage formula datapath among
// NUM_REQ requesters. Round-robin grant, one issue per cycle, ID tags travel in a
// shadow pipe and are rejoined with results into a response FIFO. Credits bound
// issued-but-unpopped results to FIFO_DEPTH so the FIFO can never overflow.
// Ports:
//   clk_i, artsn_i                 clock, async active-low reset
//   req_valid_i / req_ready_o      per-requester handshake (ready is one-hot or zero)
//   req_a_i..req_d_i               packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dp_a_o..dp_d_o, dp_valid_o     operand set issued to the datapath
//   dp_q_i, dp_q_valid_i           datapath result
//   rsp_q_o, rsp_id_o, rsp_valid_o, rsp_ready_i   response stream (FIFO head)
//   err_o                          sticky: result valid disagreed with tag valid
module formula_pipe_arbiter
  import formula_pkg::*;
#(
  parameter  int DATA_WIDTH = DP_DATA_WIDTH,
  parameter  int NUM_REQ    = DP_NUM_REQ,
  parameter  int LATENCY    = DP_LATENCY,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          artsn_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_c_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_d_i,
  output logic [DATA_WIDTH-1:0]         dp_a_o,
  output logic [DATA_WIDTH-1:0]         dp_b_o,
  output logic [DATA_WIDTH-1:0]         dp_c_o,
  output logic [DATA_WIDTH-1:0]         dp_d_o,
  output logic                          dp_valid_o,
  input  logic [DATA_WIDTH-1:0]         dp_q_i,
  input  logic                          dp_q_valid_i,
  output logic [DATA_WIDTH-1:0]         rsp_q_o,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic                          err_o
);

  localparam int CRD_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = $bits(rsp_entry_t);

  logic [CRD_W-1:0]   credits;
  logic [ID_W-1:0]    rr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               issue;
  tag_t               tag_pipe [LATENCY];
  tag_t               tail;
  logic               push;
  logic               pop;
  rsp_entry_t         push_entry;
  rsp_entry_t         head;
  logic [ENT_W-1:0]   fifo_din;
  logic [ENT_W-1:0]   fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  int                 inflight;

  // Round-robin search starting one past the last winner. Grant is also held off
  // during reset so req_ready_o is zero even if requesters are already valid.
  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    if (artsn_i && credits != '0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(rr) + k) % NUM_REQ;
        if (grant == '0 && req_valid_i[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = ID_W'(idx);
        end
      end
    end
  end

  // A grant is only ever given to a valid requester, so any grant is a handshake.
  assign issue       = |grant;
  assign req_ready_o = grant;
  assign dp_valid_o  = issue;

  always_comb begin
    dp_a_o = '0;
    dp_b_o = '0;
    dp_c_o = '0;
    dp_d_o = '0;
    if (issue) begin
      dp_a_o = req_a_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      dp_b_o = req_b_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      dp_c_o = req_c_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      dp_d_o = req_d_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The tag pipe mirrors the datapath depth, so its tail lines up with dp_q_valid_i.
  assign tail = tag_pipe[LATENCY-1];
  assign pop  = rsp_valid_o && rsp_ready_i;
  assign push = dp_q_valid_i && tail.vld;

  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      rr      <= ID_W'(NUM_REQ - 1);
      credits <= CRD_W'(FIFO_DEPTH);
      err_o   <= 1'b0;
      for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      if (issue) rr <= grant_idx;
      tag_pipe[0] <= '{vld: issue, id: grant_idx};
      for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (dp_q_valid_i != tail.vld) err_o <= 1'b1;
      // A pop's credit is only usable from the next cycle, since grant looks at
      // the registered count.
      unique case ({issue, pop})
        2'b10:   credits <= credits - CRD_W'(1);
        2'b01:   credits <= credits + CRD_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  assign push_entry = '{q: dp_q_i, id: tail.id};
  assign fifo_din   = push_entry;
  assign head       = rsp_entry_t'(fifo_dout);

  rsp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk_i),
    .rst_n (artsn_i),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rsp_valid_o = !fifo_empty;
  assign rsp_q_o     = head.q;
  assign rsp_id_o    = head.id;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < LATENCY; i++) if (tag_pipe[i].vld) inflight++;
  end

  // Credits exist precisely to make this impossible.
  ap_no_overflow: assert property (@(posedge clk_i) disable iff (!artsn_i)
    !(push && fifo_full));

  // Every credit is either free, in flight, or sitting in the FIFO. A dropped tag
  // leaks a credit, which err_o already reports.
  ap_credit_balance: assert property (@(posedge clk_i) disable iff (!artsn_i || err_o)
    (int'(credits) + int'(fifo_count) + inflight) == FIFO_DEPTH);

endmodule

// File: tb/tb_formula_pipe_arbiter.sv
// Bench for formula_pipe_arbiter: a registered 3-stage datapath stub, a
// transaction-level reference model (outstanding-result queues, round-robin
// pointer) and one task per scenario.
module tb_formula_pipe_arbiter;

  localparam int W     = 5;
  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 4;

  logic           clk_i = 1'b0;
  logic           artsn_i;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] req_a_i, req_b_i, req_c_i, req_d_i;
  logic [W-1:0]   dp_a_o, dp_b_o, dp_c_o, dp_d_o;
  logic           dp_valid_o;
  logic [W-1:0]   dp_q_i;
  logic           dp_q_valid_i;
  logic [W-1:0]   rsp_q_o;
  logic [IDW-1:0] rsp_id_o;
  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic           err_o;

  bit           va [N];
  logic [W-1:0] ra [N];
  logic [W-1:0] rb [N];
  logic [W-1:0] rc [N];
  logic [W-1:0] rd [N];
  logic         inject;

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid_i[i]       = va[i];
      req_a_i[i*W +: W]    = ra[i];
      req_b_i[i*W +: W]    = rb[i];
      req_c_i[i*W +: W]    = rc[i];
      req_d_i[i*W +: W]    = rd[i];
    end
  end

  formula_pipe_arbiter #(
    .DATA_WIDTH (W),
    .NUM_REQ    (N),
    .LATENCY    (3),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .artsn_i      (artsn_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_c_i      (req_c_i),
    .req_d_i      (req_d_i),
    .dp_a_o       (dp_a_o),
    .dp_b_o       (dp_b_o),
    .dp_c_o       (dp_c_o),
    .dp_d_o       (dp_d_o),
    .dp_valid_o   (dp_valid_o),
    .dp_q_i       (dp_q_i),
    .dp_q_valid_i (dp_q_valid_i),
    .rsp_q_o      (rsp_q_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .err_o        (err_o)
  );

  // q = ((a-b)*(3c+1) - 4d) >>> 1 on a W-bit datapath: wraps mod 2^W before the shift.
  function automatic logic signed [W-1:0] calc_q(input logic signed [W-1:0] a, b, c, d);
    int full;
    logic signed [W-1:0] t;
    full = (int'(a) - int'(b)) * (3 * int'(c) + 1) - 4 * int'(d);
    t    = full[W-1:0];
    return t >>> 1;
  endfunction

  // Datapath stub: three registered stages, cleared by the shared reset.
  logic         sv [3];
  logic [W-1:0] sq [3];
  always @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      for (int i = 0; i < 3; i++) begin
        sv[i] <= 1'b0;
        sq[i] <= '0;
      end
    end else begin
      sv[0] <= dp_valid_o;
      sq[0] <= calc_q(dp_a_o, dp_b_o, dp_c_o, dp_d_o);
      for (int i = 1; i < 3; i++) begin
        sv[i] <= sv[i-1];
        sq[i] <= sq[i-1];
      end
    end
  end
  assign dp_q_valid_i = sv[2] | inject;
  assign dp_q_i       = sq[2];

  // Reference model: each accepted request becomes a result visible 4 cycles later;
  // issued-but-unpopped results may never exceed DEPTH.
  typedef struct {
    logic [W-1:0]   q;
    logic [IDW-1:0] id;
    int             due;
  } exp_t;

  exp_t           pend [$];
  exp_t           vis  [$];
  int             rr_m = N - 1;
  bit             err_exp = 1'b0;
  int             cyc = 0;
  int             checks = 0;
  int             failures = 0;
  int             last_grant;
  bit             obs_rsp_valid;
  logic [W-1:0]   obs_q;
  logic [IDW-1:0] obs_id;
  logic [N-1:0]   obs_ready;

  task automatic reset_model();
    pend.delete();
    vis.delete();
    rr_m    = N - 1;
    err_exp = 1'b0;
  endtask

  // One clock cycle: called just after a falling edge with inputs already set.
  task automatic step();
    int           g;
    logic [N-1:0] exp_ready;
    logic [4*W-1:0] exp_ops;
    #1;
    while (pend.size() > 0 && pend[0].due <= cyc) vis.push_back(pend.pop_front());
    g = -1;
    if (pend.size() + vis.size() < DEPTH) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (rr_m + k) % N;
        if (g < 0 && va[i]) g = i;
      end
    end
    exp_ready = '0;
    exp_ops   = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      exp_ops      = {ra[g], rb[g], rc[g], rd[g]};
    end
    checks++;
    if (req_ready_o !== exp_ready) begin
      failures++;
      $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready_o, exp_ready);
    end
    checks++;
    if (dp_valid_o !== (g >= 0) || {dp_a_o, dp_b_o, dp_c_o, dp_d_o} !== exp_ops) begin
      failures++;
      $display("FAIL dp_issue cyc=%0d got v=%b ops=%h exp v=%b ops=%h", cyc, dp_valid_o,
               {dp_a_o, dp_b_o, dp_c_o, dp_d_o}, (g >= 0), exp_ops);
    end
    checks++;
    if (vis.size() > 0) begin
      if (rsp_valid_o !== 1'b1 || rsp_q_o !== vis[0].q || rsp_id_o !== vis[0].id) begin
        failures++;
        $display("FAIL rsp_head cyc=%0d got v=%b q=%h id=%0d exp v=1 q=%h id=%0d", cyc,
                 rsp_valid_o, rsp_q_o, rsp_id_o, vis[0].q, vis[0].id);
      end
    end else if (rsp_valid_o !== 1'b0 || rsp_q_o !== '0 || rsp_id_o !== '0) begin
      failures++;
      $display("FAIL rsp_empty cyc=%0d got v=%b q=%h id=%0d exp v=0 q=0 id=0", cyc,
               rsp_valid_o, rsp_q_o, rsp_id_o);
    end
    checks++;
    if (err_o !== err_exp) begin
      failures++;
      $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err_o, err_exp);
    end
    last_grant    = g;
    obs_rsp_valid = rsp_valid_o;
    obs_q         = rsp_q_o;
    obs_id        = rsp_id_o;
    obs_ready     = req_ready_o;
    if (g >= 0) begin
      pend.push_back('{q: calc_q(ra[g], rb[g], rc[g], rd[g]), id: IDW'(g), due: cyc + 4});
      rr_m = g;
    end
    if (vis.size() > 0 && rsp_ready_i) void'(vis.pop_front());
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < N; i++) va[i] = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (n) step();
  endtask

  task automatic test_reset();
    artsn_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== '0 || dp_valid_o !== 1'b0 ||
        {dp_a_o, dp_b_o, dp_c_o, dp_d_o} !== '0) begin
      failures++;
      $display("FAIL reset_issue got ready=%b v=%b ops=%h exp 0", req_ready_o, dp_valid_o,
               {dp_a_o, dp_b_o, dp_c_o, dp_d_o});
    end
    checks++;
    if (rsp_valid_o !== 1'b0 || rsp_q_o !== '0 || rsp_id_o !== '0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp got v=%b q=%h id=%0d err=%b exp 0", rsp_valid_o, rsp_q_o,
               rsp_id_o, err_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    artsn_i = 1'b1;
    reset_model();
  endtask

  task automatic test_single();
    int h;
    int r;
    for (int i = 0; i < N; i++) va[i] = 1'b0;
    rsp_ready_i = 1'b1;
    va[0] = 1'b1; ra[0] = 5'd3; rb[0] = 5'd1; rc[0] = 5'd1; rd[0] = 5'd1;
    h = -1;
    for (int k = 0; k < 10 && h < 0; k++) begin
      int c;
      c = cyc;
      step();
      if (last_grant == 0) h = c;
    end
    va[0] = 1'b0;
    r = -1;
    for (int k = 0; k < 10 && r < 0; k++) begin
      int c;
      c = cyc;
      step();
      if (obs_rsp_valid) r = c;
    end
    checks++;
    if (h < 0 || r < 0 || r - h != 4) begin
      failures++;
      $display("FAIL single_latency got handshake=%0d response=%0d exp distance 4", h, r);
    end
    checks++;
    if (obs_q !== 5'd2 || obs_id !== 2'd0) begin
      failures++;
      $display("FAIL single_value got q=%0d id=%0d exp q=2 id=0", obs_q, obs_id);
    end
    drain(4);
  endtask

  task automatic test_round_robin();
    int prev;
    int issued;
    int bad_order;
    int bad_q;
    prev = -1; issued = 0; bad_order = 0; bad_q = 0;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      va[i] = 1'b1; ra[i] = 5'd5; rb[i] = 5'd2; rc[i] = 5'd0; rd[i] = 5'd0;
    end
    repeat (20) begin
      step();
      if (last_grant >= 0) begin
        if (prev >= 0 && last_grant != (prev + 1) % N) bad_order++;
        prev = last_grant;
        issued++;
      end
      if (obs_rsp_valid && obs_q !== 5'd1) bad_q++;
    end
    checks++;
    if (bad_order != 0) begin
      failures++;
      $display("FAIL rr_order got %0d out-of-order grants exp 0", bad_order);
    end
    checks++;
    if (bad_q != 0) begin
      failures++;
      $display("FAIL rr_value got %0d responses with q!=1 exp 0", bad_q);
    end
    // Four issues, then one cycle where the popped credit is not yet usable.
    checks++;
    if (issued != 16) begin
      failures++;
      $display("FAIL rr_issue_count got=%0d exp=16", issued);
    end
    drain(8);
  endtask

  task automatic test_back_to_back_backpressure();
    int hs;
    hs = 0;
    for (int i = 0; i < N; i++) va[i] = 1'b0;
    rsp_ready_i = 1'b0;
    va[1] = 1'b1;
    ra[1] = W'($urandom); rb[1] = W'($urandom); rc[1] = W'($urandom); rd[1] = W'($urandom);
    repeat (10) begin
      step();
      if (last_grant == 1) begin
        hs++;
        ra[1] = W'($urandom); rb[1] = W'($urandom); rc[1] = W'($urandom); rd[1] = W'($urandom);
      end
    end
    checks++;
    if (hs != DEPTH || obs_ready !== '0) begin
      failures++;
      $display("FAIL bp_fill got handshakes=%0d ready=%b exp handshakes=4 ready=0", hs, obs_ready);
    end
    rsp_ready_i = 1'b1;
    step();
    checks++;
    if (last_grant != -1) begin
      failures++;
      $display("FAIL bp_pop_cycle got grant=%0d exp none", last_grant);
    end
    rsp_ready_i = 1'b0;
    step();
    checks++;
    if (last_grant != 1) begin
      failures++;
      $display("FAIL bp_regrant got grant=%0d exp 1", last_grant);
    end
    step();
    checks++;
    if (last_grant != -1 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_after got grant=%0d err=%b exp none err=0", last_grant, err_o);
    end
    drain(10);
  endtask

  task automatic test_wrap();
    bit got;
    for (int i = 0; i < N; i++) va[i] = 1'b0;
    rsp_ready_i = 1'b1;
    va[2] = 1'b1; ra[2] = 5'd15; rb[2] = 5'b10000; rc[2] = 5'd0; rd[2] = 5'd0;
    got = 1'b0;
    for (int k = 0; k < 10 && last_grant != 2; k++) step();
    va[2] = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      got = obs_rsp_valid;
    end
    checks++;
    if (!got || obs_q !== 5'b11111 || obs_id !== 2'd2) begin
      failures++;
      $display("FAIL wrap got valid=%b q=%b id=%0d exp q=11111 id=2", got, obs_q, obs_id);
    end
    drain(4);
  endtask

  task automatic test_random();
    int grants;
    grants = 0;
    for (int i = 0; i < N; i++) va[i] = 1'b0;
    repeat (300) begin
      for (int i = 0; i < N; i++) begin
        if (!va[i] && $urandom_range(1, 0) == 1) begin
          va[i] = 1'b1;
          ra[i] = W'($urandom); rb[i] = W'($urandom); rc[i] = W'($urandom); rd[i] = W'($urandom);
        end
      end
      rsp_ready_i = ($urandom_range(9, 0) < 7);
      step();
      if (last_grant >= 0) begin
        va[last_grant] = 1'b0;
        grants++;
      end
    end
    drain(12);
    checks++;
    if (grants == 0 || obs_rsp_valid !== 1'b0 || pend.size() + vis.size() != 0) begin
      failures++;
      $display("FAIL random_drain got grants=%0d rsp_valid=%b exp grants>0 rsp_valid=0",
               grants, obs_rsp_valid);
    end
  endtask

  task automatic test_spurious();
    drain(2);
    inject = 1'b1;
    step();
    inject = 1'b0;
    err_exp = 1'b1;
    repeat (5) step();
    checks++;
    if (err_o !== 1'b1 || obs_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL spurious got err=%b rsp_valid=%b exp err=1 rsp_valid=0", err_o, obs_rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    int grants;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      va[i] = 1'b1;
      ra[i] = W'($urandom); rb[i] = W'($urandom); rc[i] = W'($urandom); rd[i] = W'($urandom);
    end
    // err_o is still set from the spurious test; the model keeps expecting it.
    repeat (5) step();
    artsn_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== '0 || dp_valid_o !== 1'b0 || {dp_a_o, dp_b_o, dp_c_o, dp_d_o} !== '0 ||
        rsp_valid_o !== 1'b0 || rsp_q_o !== '0 || rsp_id_o !== '0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got ready=%b v=%b rsp_v=%b q=%h id=%0d err=%b exp all 0",
               req_ready_o, dp_valid_o, rsp_valid_o, rsp_q_o, rsp_id_o, err_o);
    end
    reset_model();
    @(negedge clk_i);
    @(negedge clk_i);
    artsn_i = 1'b1;
    step();
    checks++;
    if (last_grant != 0) begin
      failures++;
      $display("FAIL reset_first_grant got=%0d exp=0", last_grant);
    end
    grants = 1;
    repeat (6) begin
      step();
      if (last_grant >= 0) grants++;
    end
    checks++;
    if (grants != DEPTH) begin
      failures++;
      $display("FAIL reset_credits got grants=%0d exp=%0d", grants, DEPTH);
    end
    drain(10);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    inject      = 1'b0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      va[i] = 1'b0; ra[i] = '0; rb[i] = '0; rc[i] = '0; rd[i] = '0;
    end
    last_grant = -1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back_backpressure();
    test_wrap();
    test_random();
    test_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
